// File: rtl/uart_adc_report_if.sv
// Byte-stream handshake between the ADC reporter (master) and uart_tx (slave).
// send_en is a one-cycle strobe qualifying send_data; send_busy is the
// transmitter's busy flag.
interface uart_adc_report_if;
    logic       send_en;
    logic [7:0] send_data;
    logic       send_busy;

    modport master (
        output send_en,
        output send_data,
        input  send_busy
    );

    modport slave (
        input  send_en,
        input  send_data,
        output send_busy
    );
endinterface

// File: rtl/uart_adc_report.sv
// Multi-channel ADC-to-UART ASCII reporter.
// Snapshots CH_NUM channels, converts each to zero-padded decimal with a
// sequential double-dabble engine and streams one "CHk:<digits>\n" line per
// channel into uart_tx. Frames start on a periodic timer or on trig pulses.
// Optional macro REPORT_HEX_EN: skip conversion and emit ceil(DATA_W/4)
// uppercase hex digits per channel instead of DIG_NUM decimal digits.
module uart_adc_report #(
    parameter int CLK_FRE   = 50,
    parameter int SEND_FRE  = 2,
    parameter int CH_NUM    = 4,
    parameter int DATA_W    = 12,
    parameter int DIG_NUM   = 4,
    parameter int TRIG_MODE = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CH_NUM*DATA_W-1:0] adc_data,
    input  logic                     trig,
    uart_adc_report_if.master        tx,
    output logic                     frame_busy,
    output logic                     frame_done
);

    localparam int PERIOD  = CLK_FRE * 1000000 / SEND_FRE;
    localparam int TMR_W   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int HEX_DIG = (DATA_W + 3) / 4;
`ifdef REPORT_HEX_EN
    localparam int NUM_DIG = HEX_DIG;
`else
    localparam int NUM_DIG = DIG_NUM;
`endif
    localparam int LINE_LEN = NUM_DIG + 5;
    localparam int SNAP_W   = CH_NUM * DATA_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SNAP,
        ST_CONV,
        ST_SEND,
        ST_ACK_HI,
        ST_ACK_LO
    } state_t;

    state_t              state_q, state_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic                pending_q, pending_d;
    logic [SNAP_W-1:0]   snap_q, snap_d;
    logic [3:0]          ch_q, ch_d;
    logic [4:0]          b_q, b_d;
    logic                frame_done_q, frame_done_d;

    logic                timer_wrap;
    logic                req;
    logic [DATA_W-1:0]   ch_val;
    logic [7:0]          cur_byte;
    logic [3:0]          nib;
    int                  dig_idx;
`ifdef REPORT_HEX_EN
    logic [4*HEX_DIG-1:0] hex_ext;
`else
    logic [5:0]           cnt_q, cnt_d;
    logic [4*DIG_NUM-1:0] bcd_q, bcd_d, bcd_adj;
`endif

    assign ch_val     = snap_q[ch_q*DATA_W +: DATA_W];
    assign frame_busy = (state_q != ST_IDLE);
    assign frame_done = frame_done_q;

    // Free-running frame timer; wraps every PERIOD cycles and never stops.
    always_comb begin
        timer_wrap = (timer_q == TMR_W'(PERIOD - 1));
        timer_d    = timer_wrap ? '0 : timer_q + 1'b1;
    end

    // Single-bit request latch: IDLE consumes it, extra requests collapse into it.
    always_comb begin
        req       = (TRIG_MODE == 1) ? trig : timer_wrap;
        pending_d = pending_q;
        if (state_q == ST_IDLE && pending_q) begin
            pending_d = 1'b0;
        end else if (req) begin
            pending_d = 1'b1;
        end
    end

`ifndef REPORT_HEX_EN
    // Double-dabble correction: add 3 to every BCD digit >= 5 before the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < DIG_NUM; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
    end
`endif

    // Byte selector for the current line position b of channel ch.
    always_comb begin
        cur_byte = 8'h0A;
        nib      = 4'd0;
        dig_idx  = int'(b_q) - 4;
`ifdef REPORT_HEX_EN
        hex_ext                = '0;
        hex_ext[DATA_W-1:0]    = ch_val;
`endif
        if (b_q == 5'd0) begin
            cur_byte = 8'h43;
        end else if (b_q == 5'd1) begin
            cur_byte = 8'h48;
        end else if (b_q == 5'd2) begin
            cur_byte = 8'h30 + {4'd0, ch_q};
        end else if (b_q == 5'd3) begin
            cur_byte = 8'h3A;
        end else if (b_q < 5'(LINE_LEN - 1)) begin
`ifdef REPORT_HEX_EN
            nib      = hex_ext[(NUM_DIG - 1 - dig_idx)*4 +: 4];
            cur_byte = (nib < 4'd10) ? 8'h30 + {4'd0, nib} : 8'h37 + {4'd0, nib};
`else
            nib      = bcd_q[(NUM_DIG - 1 - dig_idx)*4 +: 4];
            cur_byte = 8'h30 + {4'd0, nib};
`endif
        end
    end

    // Frame sequencer: next state, datapath updates and uart_tx strobe.
    always_comb begin
        state_d      = state_q;
        snap_d       = snap_q;
        ch_d         = ch_q;
        b_d          = b_q;
        frame_done_d = 1'b0;
        tx.send_en   = 1'b0;
        tx.send_data = 8'h00;
`ifndef REPORT_HEX_EN
        cnt_d        = cnt_q;
        bcd_d        = bcd_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pending_q) begin
                    state_d = ST_SNAP;
                end
            end
            ST_SNAP: begin
                snap_d = adc_data;
                ch_d   = 4'd0;
                b_d    = 5'd0;
`ifdef REPORT_HEX_EN
                state_d = ST_SEND;
`else
                cnt_d   = 6'd0;
                bcd_d   = '0;
                state_d = ST_CONV;
`endif
            end
            ST_CONV: begin
`ifndef REPORT_HEX_EN
                bcd_d = {bcd_adj[4*DIG_NUM-2:0], ch_val[6'(DATA_W - 1) - cnt_q]};
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'(DATA_W - 1)) begin
                    b_d     = 5'd0;
                    state_d = ST_SEND;
                end
`else
                state_d = ST_SEND;
`endif
            end
            ST_SEND: begin
                if (!tx.send_busy) begin
                    tx.send_en   = 1'b1;
                    tx.send_data = cur_byte;
                    state_d      = ST_ACK_HI;
                end
            end
            ST_ACK_HI: begin
                if (tx.send_busy) begin
                    state_d = ST_ACK_LO;
                end
            end
            ST_ACK_LO: begin
                if (!tx.send_busy) begin
                    if (b_q < 5'(LINE_LEN - 1)) begin
                        b_d     = b_q + 5'd1;
                        state_d = ST_SEND;
                    end else if (ch_q < 4'(CH_NUM - 1)) begin
                        ch_d = ch_q + 4'd1;
                        b_d  = 5'd0;
`ifdef REPORT_HEX_EN
                        state_d = ST_SEND;
`else
                        cnt_d   = 6'd0;
                        bcd_d   = '0;
                        state_d = ST_CONV;
`endif
                    end else begin
                        frame_done_d = 1'b1;
                        state_d      = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            pending_q    <= 1'b0;
            snap_q       <= '0;
            ch_q         <= 4'd0;
            b_q          <= 5'd0;
            frame_done_q <= 1'b0;
`ifndef REPORT_HEX_EN
            cnt_q        <= 6'd0;
            bcd_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            pending_q    <= pending_d;
            snap_q       <= snap_d;
            ch_q         <= ch_d;
            b_q          <= b_d;
            frame_done_q <= frame_done_d;
`ifndef REPORT_HEX_EN
            cnt_q        <= cnt_d;
            bcd_q        <= bcd_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_adc_report.sv
// Scoreboard bench for uart_adc_report: a triggered 2-channel instance (A)
// and a periodic 1-channel 3-digit instance (B), each with a uart_tx model.
module tb_uart_adc_report;

    localparam int HEX_D = 3;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic [23:0] adc_a;
    logic [11:0] adc_b;
    logic        trig_a, trig_b;
    logic        frame_busy_a, frame_done_a, frame_busy_b, frame_done_b;
    logic        hold_a = 1'b0;
    int          busy_cnt_a = 0, busy_cnt_b = 0;

    int          sb_a[$];
    int          sb_b[$];
    int          n_cmp = 0, n_bad = 0;
    longint      cyc = 0;
    int          sent_a = 0, done_a = 0;
    longint      first_en_b = -1;
    longint      rise_b[$];
    logic        busy_prev_b = 1'b0;

    uart_adc_report_if if_a ();
    uart_adc_report_if if_b ();

    uart_adc_report #(.CLK_FRE(1), .SEND_FRE(1000), .CH_NUM(2), .DATA_W(12),
                      .DIG_NUM(4), .TRIG_MODE(1)) dut_a (
        .clk(clk), .rst(rst_a), .adc_data(adc_a), .trig(trig_a), .tx(if_a),
        .frame_busy(frame_busy_a), .frame_done(frame_done_a));

    uart_adc_report #(.CLK_FRE(1), .SEND_FRE(1000), .CH_NUM(1), .DATA_W(12),
                      .DIG_NUM(3), .TRIG_MODE(0)) dut_b (
        .clk(clk), .rst(rst_b), .adc_data(adc_b), .trig(trig_b), .tx(if_b),
        .frame_busy(frame_busy_b), .frame_done(frame_done_b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // uart_tx models: busy rises the cycle after send_en and lasts 10 cycles
    always @(posedge clk) begin
        if (if_a.send_en) busy_cnt_a <= 10;
        else if (busy_cnt_a > 0) busy_cnt_a <= busy_cnt_a - 1;
        if (if_b.send_en) busy_cnt_b <= 10;
        else if (busy_cnt_b > 0) busy_cnt_b <= busy_cnt_b - 1;
    end
    assign if_a.send_busy = (busy_cnt_a > 0) || hold_a;
    assign if_b.send_busy = (busy_cnt_b > 0);

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic expect_pop(input int which, input int act, input string nm);
        int e;
        if ((which == 0 ? sb_a.size() : sb_b.size()) == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got %0d, expected nothing", nm, act);
        end else begin
            e = (which == 0) ? sb_a.pop_front() : sb_b.pop_front();
            check(nm, 64'(act), 64'(e));
        end
    endtask

    // Reference model: 256 marks the frame_done pulse after a frame's bytes.
    function automatic void push_byte(input int which, input int b);
        if (which == 0) sb_a.push_back(b);
        else            sb_b.push_back(b);
    endfunction

    function automatic void push_line(input int which, input int ch, input longint v, input int dig);
        longint m, p;
        int     d;
        push_byte(which, 67);
        push_byte(which, 72);
        push_byte(which, 48 + ch);
        push_byte(which, 58);
`ifdef REPORT_HEX_EN
        m = v; p = dig;
        for (int i = 0; i < HEX_D; i++) begin
            d = int'((v >> (4 * (HEX_D - 1 - i))) & 15);
            push_byte(which, (d < 10) ? 48 + d : 55 + d);
        end
`else
        p = 1;
        for (int i = 0; i < dig; i++) p = p * 10;
        m = v % p;
        for (int i = 0; i < dig; i++) begin
            p = p / 10;
            d = int'((m / p) % 10);
            push_byte(which, 48 + d);
        end
`endif
        push_byte(which, 10);
    endfunction

    // Monitors: compare every strobed byte and frame_done against the queues
    always @(negedge clk) begin
        if (if_a.send_en) begin
            sent_a++;
            check("a_busy_low_at_send", 64'(if_a.send_busy), 64'd0);
            expect_pop(0, int'(if_a.send_data), "a_byte");
        end
        if (frame_done_a) begin
            done_a++;
            expect_pop(0, 256, "a_frame_done");
        end
        if (if_b.send_en) begin
            if (first_en_b < 0) first_en_b = cyc;
            expect_pop(1, int'(if_b.send_data), "b_byte");
        end
        if (frame_done_b) expect_pop(1, 256, "b_frame_done");
        if (frame_busy_b && !busy_prev_b) rise_b.push_back(cyc);
        busy_prev_b = frame_busy_b;
    end

    task automatic wait_empty(input int which, input int budget, input string nm);
        int n = 0;
        while ((which == 0 ? sb_a.size() : sb_b.size()) != 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= budget) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: timeout with %0d entries pending, expected 0", nm,
                     which == 0 ? sb_a.size() : sb_b.size());
        end
    endtask

    task automatic pulse_trig();
        trig_a = 1'b1;
        @(posedge clk); #1;
        trig_a = 1'b0;
    endtask

    task automatic push_frame_a(input int v0, input int v1);
        push_line(0, 0, longint'(v0), 4);
        push_line(0, 1, longint'(v1), 4);
        push_byte(0, 256);
    endtask

    task automatic frame_a(input int v0, input int v1, input string nm);
        adc_a = {12'(v1), 12'(v0)};
        push_frame_a(v0, v1);
        pulse_trig();
        wait_empty(0, 1000, nm);
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic run_a();
        int s0, s1, d0, n, y0, y1;
        rst_a = 1'b1; trig_a = 1'b0; adc_a = '0;
        repeat (4) @(posedge clk);
        #1;
        check("a_reset_send_en", 64'(if_a.send_en), 64'd0);
        check("a_reset_send_data", 64'(if_a.send_data), 64'd0);
        check("a_reset_frame_busy", 64'(frame_busy_a), 64'd0);
        check("a_reset_frame_done", 64'(frame_done_a), 64'd0);
        rst_a = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        frame_a(1234, 4095, "a_frame_1234_4095");
        frame_a(0, 9, "a_frame_0_9");
        frame_a(12'hA5F, 4095, "a_frame_a5f");
        for (int i = 0; i < 4; i++)
            frame_a(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)), "a_frame_rand");

        // requests during a frame collapse to one; snapshot isolates adc changes
        d0 = done_a;
        y0 = int'($urandom_range(0, 4095));
        y1 = int'($urandom_range(0, 4095));
        adc_a = {12'(y1), 12'(y0)};
        push_frame_a(y0, y1);
        pulse_trig();
        n = 0;
        while (!frame_busy_a && n < 20) begin @(posedge clk); #1; n++; end
        check("a_frame_started", 64'(frame_busy_a), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        y0 = int'($urandom_range(0, 4095));
        y1 = int'($urandom_range(0, 4095));
        adc_a = {12'(y1), 12'(y0)};
        push_frame_a(y0, y1);
        repeat (3) begin
            repeat (20) @(posedge clk);
            #1;
            pulse_trig();
        end
        wait_empty(0, 2000, "a_collapsed_requests");
        repeat (300) @(posedge clk);
        #1;
        check("a_frames_after_3_trigs", 64'(done_a - d0), 64'd2);

        // send_busy held high: no further strobe may occur
        s0 = sent_a;
        push_frame_a(321, 654);
        adc_a = {12'd654, 12'd321};
        pulse_trig();
        n = 0;
        while (sent_a == s0 && n < 100) begin @(posedge clk); #1; n++; end
        check("a_first_byte_seen", 64'(sent_a - s0), 64'd1);
        hold_a = 1'b1;
        s1 = sent_a;
        repeat (50) @(posedge clk);
        #1;
        check("a_no_send_while_busy", 64'(sent_a - s1), 64'd0);
        hold_a = 1'b0;
        wait_empty(0, 1000, "a_after_hold");
        repeat (5) @(posedge clk);
        #1;

        // reset in the middle of a byte abandons the frame
        s0 = sent_a;
        push_frame_a(777, 888);
        adc_a = {12'd888, 12'd777};
        pulse_trig();
        n = 0;
        while (sent_a - s0 < 3 && n < 500) begin @(posedge clk); #1; n++; end
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b1;
        @(posedge clk);
        #1;
        check("a_midrst_send_en", 64'(if_a.send_en), 64'd0);
        check("a_midrst_send_data", 64'(if_a.send_data), 64'd0);
        check("a_midrst_frame_busy", 64'(frame_busy_a), 64'd0);
        check("a_midrst_frame_done", 64'(frame_done_a), 64'd0);
        sb_a.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_a = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        frame_a(42, 4000, "a_frame_after_reset");
    endtask

    task automatic run_b();
        longint rel;
        int     v;
        rst_b = 1'b1; trig_b = 1'b0; adc_b = 12'd4095;
        repeat (5) @(posedge clk);
        #1;
        check("b_reset_send_en", 64'(if_b.send_en), 64'd0);
        check("b_reset_frame_busy", 64'(frame_busy_b), 64'd0);
        push_line(1, 0, 4095, 3);
        push_byte(1, 256);
        rst_b = 1'b0;
        rel = cyc;
        wait_empty(1, 1500, "b_frame0");
        adc_b = 12'd0;
        push_line(1, 0, 0, 3);
        push_byte(1, 256);
        wait_empty(1, 1500, "b_frame1");
        v = int'($urandom_range(0, 4095));
        adc_b = 12'(v);
        push_line(1, 0, longint'(v), 3);
        push_byte(1, 256);
        wait_empty(1, 1500, "b_frame2");
        rst_b = 1'b1;
`ifdef REPORT_HEX_EN
        check("b_first_send_latency", 64'(first_en_b - rel), 64'd1002);
`else
        check("b_first_send_latency", 64'(first_en_b - rel), 64'd1014);
`endif
        check("b_frame_starts", 64'(rise_b.size()), 64'd3);
        if (rise_b.size() >= 3) begin
            check("b_first_snap", 64'(rise_b[0] - rel), 64'd1001);
            check("b_period_1", 64'(rise_b[1] - rise_b[0]), 64'd1000);
            check("b_period_2", 64'(rise_b[2] - rise_b[1]), 64'd1000);
        end
    endtask

    initial begin
        fork
            run_a();
            run_b();
        join
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

endmodule
